// File: rtl/cavlc_scan_ctrl.sv
// CAVLC coefficient-scan sequencer: walks the 4x4 block list of a macroblock and
// drives the 9-cycle scan phase per coded block. Optional macro: CAVLC_SKIP_EMPTY_EN.
module cavlc_scan_ctrl #(
    parameter int SCAN_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] control_state,
    input  logic [3:0] cbp,
    input  logic [1:0] cbp_chroma,
    input  logic       enc_rdy,
    output logic [3:0] state,
    output logic [4:0] cnt4x4,
    output logic       busy,
    output logic       blk_end,
    output logic       mb_done
);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_INIT,
        PH_SCAN,
        PH_WAIT,
        PH_DONE
    } phase_t;

    localparam logic [2:0] CS_IDLE   = 3'd0;
    localparam logic [2:0] CS_I16    = 3'd2;
    localparam logic [2:0] SCAN_LAST = 3'(SCAN_CYC - 1);
    localparam logic [3:0] ST_IDLE   = 4'hF;

`ifdef CAVLC_SKIP_EMPTY_EN
    // Bit i set when block i of the MB's list carries coefficients.
    function automatic logic [26:0] build_mask(input logic i16, input logic [3:0] cb,
                                               input logic [1:0] cc);
        logic [26:0] m;
        logic [4:0]  idx;
        logic [4:0]  k;
        logic [4:0]  cdc;
        m   = '0;
        cdc = i16 ? 5'd17 : 5'd16;
        for (int i = 0; i < 27; i++) begin
            idx = 5'(i);
            k   = i16 ? idx - 5'd1 : idx;
            if (i16 && idx == 5'd0)
                m[i] = 1'b1;
            else if (idx < cdc)
                m[i] = cb[k[3:2]];
            else if (idx < cdc + 5'd2)
                m[i] = (cc != 2'd0);
            else if (idx < cdc + 5'd10)
                m[i] = (cc == 2'd2);
        end
        return m;
    endfunction
`else
    // Full-scan mode: every listed block is visited regardless of coded flags.
    function automatic logic [26:0] build_mask(input logic i16, input logic [3:0] unused_cb,
                                               input logic [1:0] unused_cc);
        return i16 ? {27{1'b1}} : {1'b0, {26{1'b1}}};
    endfunction
`endif

    // Lowest set index at or above 'from'; MSB of the result flags a hit.
    function automatic logic [5:0] find_next(input logic [26:0] mask, input logic [4:0] from);
        logic [5:0] r;
        r = '0;
        for (int i = 26; i >= 0; i--)
            if (mask[i] && 5'(i) >= from)
                r = {1'b1, 5'(i)};
        return r;
    endfunction

    phase_t     phase;
    logic [2:0] scnt;
    logic       i16_q;
    logic [3:0] cbp_q;
    logic [1:0] cbpc_q;

    logic       i16_in;
    logic [5:0] first_blk;
    logic [5:0] next_blk;

    // The first search runs on live inputs because the configuration is latched
    // on the same edge that loads the first block index.
    always_comb begin
        i16_in    = (control_state == CS_I16);
        first_blk = find_next(build_mask(i16_in, cbp, cbp_chroma), 5'd0);
        next_blk  = find_next(build_mask(i16_q, cbp_q, cbpc_q), cnt4x4 + 5'd1);
    end

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= PH_IDLE;
            state   <= ST_IDLE;
            cnt4x4  <= '0;
            busy    <= 1'b0;
            blk_end <= 1'b0;
            mb_done <= 1'b0;
            scnt    <= '0;
            i16_q   <= 1'b0;
            cbp_q   <= '0;
            cbpc_q  <= '0;
        end else begin
            blk_end <= 1'b0;
            mb_done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start && control_state != CS_IDLE) begin
                        i16_q  <= i16_in;
                        cbp_q  <= cbp;
                        cbpc_q <= cbp_chroma;
                        busy   <= 1'b1;
                        if (first_blk[5]) begin
                            cnt4x4 <= first_blk[4:0];
                            state  <= 4'd0;
                            phase  <= PH_INIT;
                        end else begin
                            cnt4x4  <= '0;
                            mb_done <= 1'b1;
                            phase   <= PH_DONE;
                        end
                    end
                end
                PH_INIT: begin
                    state <= 4'd1;
                    scnt  <= '0;
                    phase <= PH_SCAN;
                end
                PH_SCAN: begin
                    scnt <= scnt + 3'd1;
                    if (scnt == SCAN_LAST) begin
                        if (!next_blk[5]) begin
                            mb_done <= 1'b1;
                            state   <= ST_IDLE;
                            phase   <= PH_DONE;
                        end else if (enc_rdy) begin
                            cnt4x4 <= next_blk[4:0];
                            state  <= 4'd0;
                            phase  <= PH_INIT;
                        end else begin
                            state <= ST_IDLE;
                            phase <= PH_WAIT;
                        end
                    end else begin
                        state   <= state + 4'd1;
                        blk_end <= (scnt == SCAN_LAST - 3'd1);
                    end
                end
                PH_WAIT: begin
                    if (enc_rdy) begin
                        cnt4x4 <= next_blk[4:0];
                        state  <= 4'd0;
                        phase  <= PH_INIT;
                    end
                end
                PH_DONE: begin
                    busy  <= 1'b0;
                    phase <= PH_IDLE;
                end
                default: begin
                    phase <= PH_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Directed self-checking bench for cavlc_scan_ctrl; expected block lists follow
// CAVLC_SKIP_EMPTY_EN so the same bench covers both builds.
module tb_cavlc_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] control_state;
    logic [3:0] cbp;
    logic [1:0] cbp_chroma;
    logic       enc_rdy;
    logic [3:0] state;
    logic [4:0] cnt4x4;
    logic       busy;
    logic       blk_end;
    logic       mb_done;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    cavlc_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .control_state(control_state),
        .cbp          (cbp),
        .cbp_chroma   (cbp_chroma),
        .enc_rdy      (enc_rdy),
        .state        (state),
        .cnt4x4       (cnt4x4),
        .busy         (busy),
        .blk_end      (blk_end),
        .mb_done      (mb_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(i);
    endtask

    // Runs one MB with enc_rdy held high and checks every cycle against exp_q.
    task automatic run_mb(input string name, input logic [2:0] cs, input logic [3:0] cb,
                          input logic [1:0] cc, input bit repulse);
        control_state = cs;
        cbp           = cb;
        cbp_chroma    = cc;
        enc_rdy       = 1'b1;
        start         = 1'b1;
        tick();
        start      = 1'b0;
        cbp        = ~cb;
        cbp_chroma = (cc == 2'd2) ? 2'd0 : 2'd2;
        for (int b = 0; b < exp_q.size(); b++) begin
            total++;
            if (state !== 4'd0 || cnt4x4 !== 5'(exp_q[b]) || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s init blk#%0d: state=%0h cnt=%0d busy=%b, want state=0 cnt=%0d busy=1",
                         name, b, state, cnt4x4, busy, exp_q[b]);
            end
            for (int s = 1; s <= 8; s++) begin
                tick();
                start = repulse && b == 1 && s == 3;
                if (start) control_state = 3'd2;
                total++;
                if (state !== 4'(s) || blk_end !== (s == 8) || cnt4x4 !== 5'(exp_q[b])) begin
                    bad++;
                    $display("FAIL %s scan blk=%0d: state=%0h blk_end=%b cnt=%0d, want state=%0d blk_end=%b",
                             name, exp_q[b], state, blk_end, cnt4x4, s, s == 8);
                end
            end
            tick();
            start = 1'b0;
        end
        total++;
        if (mb_done !== 1'b1 || state !== 4'hF || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done: mb_done=%b state=%0h busy=%b, want 1 F 1", name, mb_done, state, busy);
        end
        tick();
        total++;
        if (mb_done !== 1'b0 || busy !== 1'b0 || state !== 4'hF) begin
            bad++;
            $display("FAIL %s idle: mb_done=%b busy=%b state=%0h, want 0 0 F", name, mb_done, busy, state);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; control_state = 3'd0; cbp = '0; cbp_chroma = '0; enc_rdy = 1'b1;
        #12;
        total++;
        if (state !== 4'hF || cnt4x4 !== 5'd0 || busy !== 1'b0 || blk_end !== 1'b0 || mb_done !== 1'b0) begin
            bad++;
            $display("FAIL reset: state=%0h cnt=%0d busy=%b blk_end=%b mb_done=%b, want F 0 0 0 0",
                     state, cnt4x4, busy, blk_end, mb_done);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_start;
        control_state = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || state !== 4'hF || mb_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_start: busy=%b state=%0h mb_done=%b, want 0 F 0", busy, state, mb_done);
        end
        tick();
        total++;
        if (busy !== 1'b0 || mb_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_start_late: busy=%b mb_done=%b, want 0 0", busy, mb_done);
        end
    endtask

    task automatic test_i16_full;
        push_range(0, 26);
        run_mb("i16_full", 3'd2, 4'hF, 2'd2, 1'b0);
    endtask

    task automatic test_i4_sparse;
`ifdef CAVLC_SKIP_EMPTY_EN
        push_range(12, 15);
`else
        push_range(0, 25);
`endif
        run_mb("i4_sparse", 3'd1, 4'b1000, 2'd0, 1'b0);
    endtask

    task automatic test_empty_mb;
`ifndef CAVLC_SKIP_EMPTY_EN
        push_range(0, 25);
`endif
        run_mb("empty_mb", 3'd3, 4'h0, 2'd0, 1'b0);
    endtask

    task automatic test_start_ignored;
`ifdef CAVLC_SKIP_EMPTY_EN
        push_range(0, 4);
        push_range(9, 12);
        push_range(17, 18);
`else
        push_range(0, 26);
`endif
        run_mb("start_ignored", 3'd2, 4'b0101, 2'd1, 1'b1);
    endtask

    task automatic test_wait;
        int n;
        control_state = 3'd1; cbp = 4'hF; cbp_chroma = 2'd0; enc_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b <= 3; b++) begin
            total++;
            if (state !== 4'd0 || cnt4x4 !== 5'(b)) begin
                bad++;
                $display("FAIL wait init: state=%0h cnt=%0d, want 0 %0d", state, cnt4x4, b);
            end
            for (int s = 1; s <= 8; s++) begin
                tick();
                if (b == 3 && s == 8) enc_rdy = 1'b0;
            end
            tick();
        end
        for (int w = 1; w <= 5; w++) begin
            total++;
            if (state !== 4'hF || cnt4x4 !== 5'd3 || busy !== 1'b1) begin
                bad++;
                $display("FAIL wait hold cyc%0d: state=%0h cnt=%0d busy=%b, want F 3 1", w, state, cnt4x4, busy);
            end
            if (w == 5) enc_rdy = 1'b1;
            tick();
        end
        total++;
        if (state !== 4'd0 || cnt4x4 !== 5'd4) begin
            bad++;
            $display("FAIL wait resume: state=%0h cnt=%0d, want 0 4", state, cnt4x4);
        end
        n = 0;
        while (mb_done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        total++;
        if (mb_done !== 1'b1 || cnt4x4 !== (`ifdef CAVLC_SKIP_EMPTY_EN 5'd15 `else 5'd25 `endif)) begin
            bad++;
            $display("FAIL wait finish: mb_done=%b cnt=%0d after %0d cycles", mb_done, cnt4x4, n);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        control_state = 3'd1; cbp = 4'hF; cbp_chroma = 2'd0; enc_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(state === 4'd5 && cnt4x4 === 5'd7) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (state !== 4'd5 || cnt4x4 !== 5'd7) begin
            bad++;
            $display("FAIL reset_mid reach: state=%0h cnt=%0d, want 5 7", state, cnt4x4);
        end
        rst = 1'b1;
        #1;
        total++;
        if (state !== 4'hF || cnt4x4 !== 5'd0 || busy !== 1'b0 || blk_end !== 1'b0 || mb_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: state=%0h cnt=%0d busy=%b blk_end=%b mb_done=%b, want F 0 0 0 0",
                     state, cnt4x4, busy, blk_end, mb_done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mb_done !== 1'b0 || busy !== 1'b0 || state !== 4'hF) begin
                bad++;
                $display("FAIL reset_mid after: mb_done=%b busy=%b state=%0h, want 0 0 F", mb_done, busy, state);
            end
        end
`ifdef CAVLC_SKIP_EMPTY_EN
        push_range(0, 3);
`else
        push_range(0, 25);
`endif
        run_mb("restart", 3'd3, 4'b0001, 2'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_start();
        test_i16_full();
        test_i4_sparse();
        test_empty_mb();
        test_wait();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cavlc_scan_ctrl.md
Name: cavlc_scan_ctrl

Overview:
- Sequencer for the CAVLC coefficient-scan datapath (total-coeff/total-zeros counter and the level/run stages after it).
- Per macroblock, walks the 4x4 block list for the current MB type.
- For each coded block, drives the 9-cycle scan phase code (scan_init, scan_cycle0..7; two coefficients per cycle) and the block index cnt4x4.
- Waits for the downstream encoder before starting the next block, and reports MB completion to the top-level encoder controller.

Parameters:
- SCAN_CYC, 8, scan cycles per 4x4 block (2 coeffs/cycle). Fixed by the datapath and not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse: begin MB; accepted only when busy=0
- control_state  in  3  MB type: IDLE=0, E_INTRA4x4=1, E_INTRA16x16=2, E_P16x16=3, E_P16x8=4, E_P8x16=5, E_P8x8=6; sampled on accepted start
- cbp  in  4  luma 8x8 coded-block flags; sampled on accepted start
- cbp_chroma  in  2  0 none, 1 DC only, 2 DC+AC; sampled on accepted start
- enc_rdy  in  1  downstream ready to take next block
- state  out  4  scan phase: 0 scan_init, 1..8 scan_cycle0..7, 4'hF idle/wait
- cnt4x4  out  5  current block index
- busy  out  1  MB in progress
- blk_end  out  1  1-cycle pulse coincident with scan_cycle7
- mb_done  out  1  1-cycle pulse after the last block completes

Behaviour:
- Reset (async, rst=1):
  - state=4'hF, cnt4x4=0, busy=0, blk_end=0, mb_done=0.
  - The FSM returns to IDLE immediately, mid-MB included; the MB is abandoned with no mb_done.
- FSM states: IDLE, INIT, SCAN, WAIT, DONE.
  - IDLE: waits for start. If start=1 and control_state!=0: latch the configuration, busy<=1, cnt4x4<=first coded block, go to INIT. If control_state==0, start is ignored.
  - INIT: one cycle, state=0. Go to SCAN.
  - SCAN: state=1..8, advancing 1 per cycle. An internal 3-bit counter wraps 7->0. At state=8, blk_end=1.
  - Leaving SCAN (after state=8):
    - no further coded block -> DONE;
    - else enc_rdy=1 (sampled in the state=8 cycle) -> INIT with cnt4x4=next coded block;
    - else -> WAIT.
  - WAIT: state=4'hF, cnt4x4 held. On enc_rdy=1 -> INIT with the next index.
  - DONE: mb_done=1 for one cycle, busy<=0, state=4'hF -> IDLE. cnt4x4 holds its last value.
- Block lists, in order:
  - INTRA16x16: 0 luma DC, 1..16 luma AC, 17 Cb DC, 18 Cr DC, 19..26 chroma AC.
  - Others: 0..15 luma, 16 Cb DC, 17 Cr DC, 18..25 chroma AC.
- Coded test:
  - Luma index k (non-I16 k, I16 AC k-1) is coded iff cbp[k>>2].
  - I16 luma DC is always coded.
  - Chroma DC is coded iff cbp_chroma!=0.
  - Chroma AC is coded iff cbp_chroma==2.
- Next-index search is combinational over the latched configuration, so skipped blocks cost zero cycles.
- If no block is coded (only possible outside I16), go from IDLE straight to DONE: the mb_done pulse follows accept by 1 cycle.
- Latency per coded block with enc_rdy held at 1: 9 cycles.
- start while busy=1 is ignored and not queued.
- cbp and cbp_chroma changes mid-MB have no effect.
- enc_rdy outside the state=8 cycle and WAIT is ignored.

Optional Feature:
- CAVLC_SKIP_EMPTY_EN:
  - Defined: uncoded blocks are skipped as described above.
  - Undefined: every index in the list is scanned regardless of cbp/cbp_chroma, and the datapath emits zero-coefficient blocks. Used for bring-up and for bit-exact comparison against the reference software in full-scan mode.

Test Plan:
- I16, cbp=4'hF, cbp_chroma=2, enc_rdy=1 -> cnt4x4 0..26 in order, 27*9=243 scan cycles, mb_done 1 cycle after the final state=8, busy low the cycle after that.
- INTRA4x4, cbp=4'b1000, cbp_chroma=0 (skip enabled) -> only blocks 12..15 scanned (36 cycles), then mb_done.
- P16x16, cbp=0, cbp_chroma=0 -> mb_done the cycle after accept; state stays 4'hF.
- INTRA4x4, cbp=4'hF, enc_rdy=0 during block 3's state=8, raised 5 cycles later -> state=4'hF and cnt4x4=3 for 5 cycles, then INIT with cnt4x4=4.
- Assert rst during block 7 scan cycle 4 -> immediate idle outputs, no mb_done; a new start is then accepted normally.
- start re-pulsed mid-MB -> ignored, sequence unchanged. CAVLC_SKIP_EMPTY_EN undefined with cbp=0 -> all 26 P-type blocks scanned.
